// File: rtl/rtc_hms_bcd_pkg.sv
// Shared mode encoding and BCD field limits for the HH:MM:SS timekeeper.
package rtc_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10
    } mode_t;

    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;
    localparam logic [7:0] HR_MAX  = 8'h23;

endpackage

// File: rtl/rtc_hms_bcd_counter.sv
// Two-digit packed-BCD modulo counter; wraps to 00 after MAX and flags the wrap as carry.
module bcd_mod_counter
    import rtc_pkg::*;
#(
    parameter logic [7:0] MAX = SEC_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);

    assign carry = inc & (value == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            if (value == MAX) begin
                value <= '0;
            end else if (value[3:0] == 4'h9) begin
                value <= {value[7:4] + 4'h1, 4'h0};
            end else begin
                value <= {value[7:4], value[3:0] + 4'h1};
            end
        end
    end

endmodule

// File: rtl/rtc_hms_bcd.sv
// 24 h BCD time-of-day keeper advanced by rising edges of an asynchronous seconds tick,
// with a button-driven set mode for hours and minutes.
module rtc_hms_bcd
    import rtc_pkg::*;
#(
    parameter int unsigned TICK_SYNC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic [1:0] mode,
    output logic       sec_pulse,
    output logic       day_wrap
);

    logic [TICK_SYNC-1:0] sync;
    logic                 prev;
    logic                 rise;
    mode_t                state;

    logic count;
    logic ss_clr, ss_carry;
    logic mm_inc, mm_carry;
    logic hh_inc, hh_carry;

    // Chain and history reset high so a tick already high at reset release is not a second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[TICK_SYNC-2:0], tick_in};
            prev <= sync[TICK_SYNC-1];
        end
    end

    assign rise = sync[TICK_SYNC-1] & ~prev;

    // A mode change in the same cycle takes precedence over both a tick and an inc.
    assign count  = (state == RUN) & rise & ~btn_mode;
    assign ss_clr = (state != RUN) | btn_mode;
    assign mm_inc = ss_carry | ((state == SET_M) & btn_inc & ~btn_mode);
    assign hh_inc = ((state == RUN) & mm_carry) | ((state == SET_H) & btn_inc & ~btn_mode);

    bcd_mod_counter #(.MAX(SEC_MAX)) u_ss (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (count),
        .clr   (ss_clr),
        .value (ss_bcd),
        .carry (ss_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_mm (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mm_inc),
        .clr   (1'b0),
        .value (mm_bcd),
        .carry (mm_carry)
    );

    bcd_mod_counter #(.MAX(HR_MAX)) u_hh (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hh_inc),
        .clr   (1'b0),
        .value (hh_bcd),
        .carry (hh_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
        end else begin
            if (btn_mode) begin
                case (state)
                    RUN:     state <= SET_H;
                    SET_H:   state <= SET_M;
                    default: state <= RUN;
                endcase
            end
            sec_pulse <= count;
            day_wrap  <= count & hh_carry;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_rtc_hms_bcd.sv
// Directed bench for rtc_hms_bcd, checked every cycle against an integer time-of-day model.
module tb_rtc_hms_bcd;

    logic       clk;
    logic       rst_n;
    logic       tick_in;
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] hh_bcd;
    logic [7:0] mm_bcd;
    logic [7:0] ss_bcd;
    logic [1:0] mode;
    logic       sec_pulse;
    logic       day_wrap;

    rtc_hms_bcd #(.TICK_SYNC(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_in   (tick_in),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .hh_bcd    (hh_bcd),
        .mm_bcd    (mm_bcd),
        .ss_bcd    (ss_bcd),
        .mode      (mode),
        .sec_pulse (sec_pulse),
        .day_wrap  (day_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    // Model: plain integers for time and mode (0 run, 1 set hours, 2 set minutes).
    int exp_h = 0, exp_m = 0, exp_s = 0, exp_mode = 0;
    int exp_pulse = 0, exp_wrap = 0;

    logic        cap_pulse, cap_wrap;
    logic [23:0] cap_time;

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t, o;
        t = 4'(n / 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("hh", 32'(hh_bcd), 32'(to_bcd(exp_h)));
            check("mm", 32'(mm_bcd), 32'(to_bcd(exp_m)));
            check("ss", 32'(ss_bcd), 32'(to_bcd(exp_s)));
            check("mode", 32'(mode), exp_mode);
            check("sec_pulse", 32'(sec_pulse), exp_pulse);
            check("day_wrap", 32'(day_wrap), exp_wrap);
        end
    end

    task automatic advance();
        int t;
        t = exp_h * 3600 + exp_m * 60 + exp_s + 1;
        exp_wrap = (t == 86400) ? 1 : 0;
        t = t % 86400;
        exp_h = t / 3600;
        exp_m = (t / 60) % 60;
        exp_s = t % 60;
    endtask

    task automatic mode_step();
        exp_mode = (exp_mode + 1) % 3;
        if (exp_mode == 1) exp_s = 0;
    endtask

    task automatic do_tick();
        @(negedge clk) tick_in = 1'b1;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        if (exp_mode == 0) begin
            advance();
            exp_pulse = 1;
        end
        cap_pulse = sec_pulse;
        cap_wrap  = day_wrap;
        cap_time  = {hh_bcd, mm_bcd, ss_bcd};
        @(posedge clk);
        #1;
        exp_pulse = 0;
        exp_wrap  = 0;
        @(negedge clk) tick_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press(input bit m, input bit i);
        @(negedge clk);
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        if (m) begin
            mode_step();
        end else if (i && exp_mode == 1) begin
            exp_h = (exp_h + 1) % 24;
        end else if (i && exp_mode == 2) begin
            exp_m = (exp_m + 1) % 60;
        end
    endtask

    // btn_mode lands on the same edge the synchronised rise is seen.
    task automatic tick_with_mode();
        @(negedge clk) tick_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) btn_mode = 1'b1;
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        mode_step();
        @(negedge clk) tick_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        tick_in = 1'b1;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        #23;
        check("reset_time", 32'({hh_bcd, mm_bcd, ss_bcd}), 32'h0);
        check("reset_mode", 32'(mode), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        cmp_en = 1;

        // Tick already high at release: no second may be counted.
        repeat (100) @(negedge clk);
        check("idle_time", 32'({hh_bcd, mm_bcd, ss_bcd}), 32'h0);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);

        do_tick();
        check("first_tick_ss", 32'(cap_time), 32'h000001);
        check("first_tick_pulse", 32'(cap_pulse), 32'h1);

        press(1, 0);
        repeat (23) press(0, 1);
        press(1, 0);
        repeat (59) press(0, 1);
        press(1, 0);
        check("set_2359", 32'({hh_bcd, mm_bcd, ss_bcd}), 32'h235900);
        repeat (59) do_tick();
        check("at_235959", 32'({hh_bcd, mm_bcd, ss_bcd}), 32'h235959);
        do_tick();
        check("wrap_time", 32'(cap_time), 32'h000000);
        check("wrap_pulse", 32'(cap_pulse), 32'h1);
        check("wrap_flag", 32'(cap_wrap), 32'h1);

        // Ticks ignored in set mode; hour digit carry 09->10, 19->20, 23->00.
        press(1, 0);
        do_tick();
        do_tick();
        for (int i = 1; i <= 24; i++) begin
            press(0, 1);
            if (i == 10) check("hh_10", 32'(hh_bcd), 32'h10);
            if (i == 20) check("hh_20", 32'(hh_bcd), 32'h20);
        end
        check("hh_wrap", 32'(hh_bcd), 32'h00);

        press(1, 1);
        check("mode_beats_inc", 32'({mode, hh_bcd}), 32'h200);
        press(1, 0);
        repeat (5) do_tick();
        check("at_000005", 32'(ss_bcd), 32'h05);
        tick_with_mode();
        check("mode_beats_tick", 32'({mode, ss_bcd}), 32'h100);
        press(1, 0);
        tick_with_mode();
        check("setm_to_run_tick", 32'({mode, ss_bcd}), 32'h000);

        // Abandon a set sequence at 12:34:00 with an asynchronous reset.
        press(1, 0);
        repeat (12) press(0, 1);
        press(1, 0);
        repeat (34) press(0, 1);
        check("set_1234", 32'({hh_bcd, mm_bcd, ss_bcd}), 32'h123400);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_h = 0; exp_m = 0; exp_s = 0; exp_mode = 0;
        #1;
        check("async_rst_time", 32'({hh_bcd, mm_bcd, ss_bcd}), 32'h0);
        check("async_rst_mode", 32'(mode), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        do_tick();
        check("after_rst_tick", 32'(cap_time), 32'h000001);

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
